// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants and elaboration helpers for the single-clock FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int unsigned ae, input int unsigned af,
                                     input int unsigned depth);
        return (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// FIFO producer/consumer bundle; master drives requests, slave (the FIFO) drives status.
interface sync_fifo_ctrl_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ctrl_mem.sv
// WIDTH x DEPTH register array: synchronous write, asynchronous read.
module sync_fifo_mem #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, flags, error pulses,
// and either a registered read port or first-word-fall-through output.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned AF_THRESH = 14
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_ctrl_if.slave  bus
);

    localparam int unsigned ADDR_W = addr_w(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_ctrl: DEPTH must be a power of 2 and >= 2");
    end
    if (!thresh_ok(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_thresh
        $error("sync_fifo_ctrl: need AE_THRESH < AF_THRESH <= DEPTH");
    end
    if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
        $error("sync_fifo_ctrl: FWFT must be 0 or 1");
    end

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full, empty, wr_acc, rd_acc;
    logic [WIDTH-1:0]  mem_rdata;

    always_comb begin
        full        = (count_q == CNT_W'(DEPTH));
        empty       = (count_q == '0);
        wr_acc      = bus.wr_en & ~full;
        rd_acc      = bus.rd_en & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        rd_valid_d  = rd_acc;
        overflow_d  = bus.wr_en & full;
        underflow_d = bus.rd_en & empty;
        if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            dout_d   = mem_rdata;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Write port gated by reset so a same-cycle reset leaves memory untouched.
    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (wr_acc & ~rst),
        .waddr(wr_ptr_q),
        .wdata(bus.data_in),
        .raddr(rd_ptr_q),
        .rdata(mem_rdata)
    );

    assign bus.data_out     = (FWFT == FIFO_FWFT) ? mem_rdata : dout_q;
    assign bus.rd_valid     = (FWFT == FIFO_FWFT) ? ~empty : rd_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed scoreboard bench for sync_fifo_ctrl in standard and FWFT modes.
module tb_sync_fifo_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_ctrl_if #(.DEPTH(16), .WIDTH(8)) s_if ();
    sync_fifo_ctrl_if #(.DEPTH(16), .WIDTH(8)) f_if ();

    sync_fifo_ctrl #(.DEPTH(16), .WIDTH(8), .FWFT(0), .AE_THRESH(2), .AF_THRESH(14))
        dut_std (.clk(clk), .rst(rst), .bus(s_if));
    sync_fifo_ctrl #(.DEPTH(16), .WIDTH(8), .FWFT(1), .AE_THRESH(2), .AF_THRESH(14))
        dut_fwft (.clk(clk), .rst(rst), .bus(f_if));

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fexp_q[$];
    logic [7:0] model_q[$];
    logic [7:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: standard port on rd_valid, FWFT port on an actual pop.
    always @(negedge clk) begin
        if (s_if.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL std_unexpected_valid: got data %0h expected no rd_valid", s_if.data_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("std_rd_data", 32'(s_if.data_out), 32'(mon_e));
            end
        end
        if (f_if.rd_valid === 1'b1 && f_if.rd_en === 1'b1) begin
            if (fexp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL fwft_unexpected_pop: got data %0h expected no pop", f_if.data_out);
            end else begin
                mon_e = fexp_q.pop_front();
                chk("fwft_rd_data", 32'(f_if.data_out), 32'(mon_e));
            end
        end
    end

    initial begin
        rst = 1'b1;
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.data_in = '0;
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.data_in = '0;
        step(); step();
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_count", 32'(s_if.count), 0);
            chk("rst_empty", 32'(s_if.empty), 1);
            chk("rst_almost_empty", 32'(s_if.almost_empty), 1);
            chk("rst_full", 32'(s_if.full), 0);
            chk("rst_rd_valid", 32'(s_if.rd_valid), 0);
            chk("rst_data_out", 32'(s_if.data_out), 0);
        end

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            s_if.wr_en = 1'b1; s_if.data_in = 8'(i);
            model_q.push_back(8'(i));
            step();
            chk("fill_count", 32'(s_if.count), 32'(i + 1));
            chk("fill_almost_full", 32'(s_if.almost_full), 32'((i + 1) >= 14));
            chk("fill_full", 32'(s_if.full), 32'((i + 1) == 16));
            chk("fill_almost_empty", 32'(s_if.almost_empty), 32'((i + 1) <= 2));
        end
        s_if.data_in = 8'hEE;
        step();
        chk("overflow_pulse", 32'(s_if.overflow), 1);
        chk("overflow_count", 32'(s_if.count), 16);
        s_if.wr_en = 1'b0;
        step();
        chk("overflow_clear", 32'(s_if.overflow), 0);
        chk("overflow_count_hold", 32'(s_if.count), 16);

        // Drain
        for (int i = 0; i < 16; i++) begin
            s_if.rd_en = 1'b1;
            exp_q.push_back(model_q.pop_front());
            step();
            chk("drain_rd_valid", 32'(s_if.rd_valid), 1);
            chk("drain_count", 32'(s_if.count), 32'(15 - i));
        end
        s_if.rd_en = 1'b0;
        step();
        chk("drained_empty", 32'(s_if.empty), 1);
        chk("drained_rd_valid", 32'(s_if.rd_valid), 0);

        // Read from empty
        s_if.rd_en = 1'b1;
        step();
        chk("underflow_pulse", 32'(s_if.underflow), 1);
        chk("underflow_rd_valid", 32'(s_if.rd_valid), 0);
        chk("underflow_count", 32'(s_if.count), 0);
        s_if.rd_en = 1'b0;
        step();
        chk("underflow_clear", 32'(s_if.underflow), 0);

        // Half fill, then simultaneous read+write across the pointer wrap
        for (int i = 0; i < 8; i++) begin
            s_if.wr_en = 1'b1; s_if.data_in = 8'(8'h40 + i);
            model_q.push_back(8'(8'h40 + i));
            step();
        end
        chk("half_count", 32'(s_if.count), 8);
        for (int k = 0; k < 20; k++) begin
            s_if.wr_en = 1'b1; s_if.rd_en = 1'b1; s_if.data_in = 8'(8'h80 + k);
            exp_q.push_back(model_q.pop_front());
            model_q.push_back(8'(8'h80 + k));
            step();
            chk("rw_count", 32'(s_if.count), 8);
        end
        s_if.wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(model_q.pop_front());
            step();
        end
        s_if.rd_en = 1'b0;
        step();
        chk("rw_drained_empty", 32'(s_if.empty), 1);

        // Reset mid-burst
        for (int i = 0; i < 10; i++) begin
            s_if.wr_en = 1'b1; s_if.data_in = 8'(8'hD0 + i);
            step();
        end
        chk("burst_count", 32'(s_if.count), 10);
        rst = 1'b1;
        step();
        rst = 1'b0; s_if.wr_en = 1'b0;
        chk("midrst_count", 32'(s_if.count), 0);
        chk("midrst_empty", 32'(s_if.empty), 1);
        chk("midrst_almost_empty", 32'(s_if.almost_empty), 1);
        chk("midrst_full", 32'(s_if.full), 0);
        chk("midrst_almost_full", 32'(s_if.almost_full), 0);
        chk("midrst_data_out", 32'(s_if.data_out), 0);
        s_if.wr_en = 1'b1; s_if.data_in = 8'h3C;
        step();
        s_if.wr_en = 1'b0;
        chk("post_rst_count", 32'(s_if.count), 1);
        s_if.rd_en = 1'b1;
        exp_q.push_back(8'h3C);
        step();
        s_if.rd_en = 1'b0;
        step();

        // FWFT mode
        f_if.wr_en = 1'b1; f_if.data_in = 8'hA5;
        step();
        f_if.wr_en = 1'b0;
        chk("fwft_empty", 32'(f_if.empty), 0);
        chk("fwft_rd_valid", 32'(f_if.rd_valid), 1);
        chk("fwft_data_out", 32'(f_if.data_out), 32'hA5);
        step();
        chk("fwft_data_hold", 32'(f_if.data_out), 32'hA5);
        f_if.rd_en = 1'b1;
        fexp_q.push_back(8'hA5);
        step();
        f_if.rd_en = 1'b0;
        chk("fwft_pop_empty", 32'(f_if.empty), 1);
        chk("fwft_pop_rd_valid", 32'(f_if.rd_valid), 0);
        f_if.wr_en = 1'b1; f_if.data_in = 8'hB1;
        step();
        f_if.data_in = 8'hC2;
        step();
        f_if.wr_en = 1'b0;
        chk("fwft_count2", 32'(f_if.count), 2);
        f_if.rd_en = 1'b1;
        fexp_q.push_back(8'hB1);
        step();
        fexp_q.push_back(8'hC2);
        step();
        f_if.rd_en = 1'b0;
        chk("fwft_drained", 32'(f_if.empty), 1);

        for (int i = 0; i < 10 && (exp_q.size() != 0 || fexp_q.size() != 0); i++) step();
        chk("scoreboard_drained", 32'(exp_q.size() + fexp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO, successor to the dual-clock FIFO, for paths where producer and consumer share one clock. Adds an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. Drop-in buffer between same-clock pipeline stages; no gray-code or CDC logic.

Parameters:
DEPTH, 16, number of entries; power of 2, >= 2.
WIDTH, 8, data width in bits.
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH.
AF_THRESH, 14, almost_full asserted when count >= AF_THRESH; requires AE_THRESH < AF_THRESH <= DEPTH.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  write request.
data_in  in  WIDTH  write data.
rd_en  in  1  read request (pop in FWFT mode).
data_out  out  WIDTH  read data.
rd_valid  out  1  data_out valid (see Behaviour).
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_THRESH.
almost_empty  out  1  count <= AE_THRESH.
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  out  1  one-cycle error pulse.
underflow  out  1  one-cycle error pulse.

Behaviour:
- Interface decided: one clock clk; reset rst is synchronous and active-high.
- State: wr_ptr, rd_ptr, binary, ADDR_W = $clog2(DEPTH) bits, wrap DEPTH-1 -> 0; count register ADDR_W+1 bits.
- wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty. Flags taken from current-cycle registered count.
- Full blocks writes unconditionally, even with simultaneous accepted read. Empty blocks reads unconditionally, even with simultaneous write.
- count next: +1 if wr_acc only; -1 if rd_acc only; unchanged if both or neither. Never exceeds DEPTH nor goes below 0.
- All flags are combinational decodes of count; they update the cycle after the accepting edge.
- Write: on wr_acc, mem[wr_ptr] <= data_in, wr_ptr++.
- Standard mode (FWFT=0): on rd_acc, data_out <= mem[rd_ptr], rd_ptr++, rd_valid <= 1 next cycle, else rd_valid <= 0. data_out holds last value when no read. Latency rd_en -> data 1 cycle.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] continuously; rd_valid = ~empty; rd_acc pops (rd_ptr++). Write into empty FIFO visible on data_out one cycle after the write edge.
- Simultaneous read+write at count 1..DEPTH-1: both occur, count unchanged; a read never returns the same-cycle write data except through normal ordering.
- overflow <= wr_en & full; underflow <= rd_en & empty; registered one-cycle pulses, per offending cycle.
- Reset (including mid-operation): wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0, data_out=0 in standard mode. Memory contents not cleared; reset wins over same-cycle wr_en/rd_en.

Decomposition:
- Shared package fifo_pkg: ADDR_W function/localparam derivation, FIFO mode constants (FIFO_STD=0, FIFO_FWFT=1), elaboration checks for DEPTH power of 2 and threshold ordering.
- One sub-module: sync_fifo_mem (WIDTH x DEPTH register array, synchronous write, asynchronous read port); controller owns pointers, count, flags, read register.

Test Plan:
- Reset then idle: count=0, empty=1, almost_empty=1, full=0, rd_valid=0, data_out=0 for 5 cycles.
- Standard mode, write 0x00..0x0F: after 14th write almost_full=1, after 16th full=1 count=16; 17th wr_en -> overflow pulses one cycle, count stays 16, then 16 reads return 0x00..0x0F each 1 cycle after rd_en.
- Read from empty: rd_en=1 with count=0 -> underflow pulses, rd_valid=0, count stays 0, pointers unchanged.
- Simultaneous wr_en+rd_en at count=8 for 20 cycles: count stays 8, data in order across pointer wrap 15 -> 0.
- FWFT mode: single write 0xA5 to empty -> next cycle empty=0, rd_valid=1, data_out=0xA5 without rd_en; rd_en pops -> empty=1 following cycle.
- Reset mid-burst at count=10 with wr_en=1: next cycle count=0, empty=1, flags cleared; subsequent write/read round-trips 0x3C correctly.
